// File: rtl/axis_pair_stream_checker.sv
// axis_pair_stream_checker
//   AXI4-Stream sink for the pair-framed stream. Every pair is a tag beat
//   (byte0 = pair index) followed by a payload beat (byte0 = MARKER). All
//   other bytes must be zero, and TLAST marks the final payload beat of a
//   frame. One status record is produced per pair, and frame and error
//   counters are maintained.
//
// Ports
//   aclk, areset        clock, synchronous active-high reset
//   s_axis_*            stream slave (tdata, tvalid, tready, tlast)
//   rec_valid/rec_ready status record handshake
//   rec_index, rec_err  tag of the pair and its error bits
//                       [0] index, [1] marker, [2] nonzero pad, [3] TLAST placement
//   frame_done          one-cycle pulse while the frame-end state is active
//   pair_cnt            pairs accepted in the current frame
//   err_cnt             saturating count of pairs with any error bit set
//   busy                high while a payload beat is awaited
module axis_pair_stream_checker #(
  parameter int unsigned DATA_W      = 512,
  parameter logic [7:0]  MARKER      = 8'h9E,
  parameter int unsigned FRAME_PAIRS = 12,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [7:0]        rec_index,
  output logic [3:0]        rec_err,
  output logic              frame_done,
  output logic [8:0]        pair_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_TAG,
    ST_PAYLOAD,
    ST_DONE
  } state_t;

  localparam logic [8:0] LAST_CNT = 9'(FRAME_PAIRS - 1);

  state_t           state_q,     state_d;
  logic [7:0]       exp_idx_q,   exp_idx_d;
  logic [7:0]       tag_q,       tag_d;
  logic [3:0]       acc_err_q,   acc_err_d;
  logic             rec_valid_q, rec_valid_d;
  logic [7:0]       rec_index_q, rec_index_d;
  logic [3:0]       rec_err_q,   rec_err_d;
  logic [8:0]       pair_cnt_q,  pair_cnt_d;
  logic [CNT_W-1:0] err_cnt_q,   err_cnt_d;

  logic       tready;
  logic       accept;
  logic       pad_nz;
  logic [7:0] byte0;
  logic       final_pair;
  logic [3:0] pair_err;

  assign byte0  = s_axis_tdata[7:0];
  assign pad_nz = |s_axis_tdata[DATA_W-1:8];

  // In PAYLOAD the beat may be taken whenever the record slot is free or is
  // being drained this very cycle, so consume and refill can coincide.
  always_comb begin
    tready = 1'b0;
    if (!areset) begin
      unique case (state_q)
        ST_TAG:     tready = 1'b1;
        ST_PAYLOAD: tready = !(rec_valid_q && !rec_ready);
        default:    tready = 1'b0;
      endcase
    end
  end

  assign accept     = s_axis_tvalid && tready;
  assign final_pair = (pair_cnt_q == LAST_CNT);
  assign pair_err   = acc_err_q | {(s_axis_tlast != final_pair), pad_nz,
                                   (byte0 != MARKER), 1'b0};

  always_comb begin
    state_d     = state_q;
    exp_idx_d   = exp_idx_q;
    tag_d       = tag_q;
    acc_err_d   = acc_err_q;
    rec_valid_d = rec_valid_q;
    rec_index_d = rec_index_q;
    rec_err_d   = rec_err_q;
    pair_cnt_d  = pair_cnt_q;
    err_cnt_d   = err_cnt_q;

    if (rec_ready) begin
      rec_valid_d = 1'b0;
    end

    unique case (state_q)
      ST_TAG: begin
        if (accept) begin
          tag_d     = byte0;
          acc_err_d = {s_axis_tlast, pad_nz, 1'b0, (byte0 != exp_idx_q)};
          state_d   = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (accept) begin
          rec_valid_d = 1'b1;
          rec_index_d = tag_q;
          rec_err_d   = pair_err;
          pair_cnt_d  = pair_cnt_q + 9'd1;
          if ((pair_err != 4'd0) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
          end
          // Following the received tag rather than the expected one lets a
          // single bad index be reported once instead of cascading.
          exp_idx_d   = tag_q + 8'd1;
          state_d     = (final_pair || s_axis_tlast) ? ST_DONE : ST_TAG;
        end
      end
      default: begin
        exp_idx_d  = '0;
        pair_cnt_d = '0;
        state_d    = ST_TAG;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= ST_TAG;
      exp_idx_q   <= '0;
      tag_q       <= '0;
      acc_err_q   <= '0;
      rec_valid_q <= 1'b0;
      rec_index_q <= '0;
      rec_err_q   <= '0;
      pair_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      exp_idx_q   <= exp_idx_d;
      tag_q       <= tag_d;
      acc_err_q   <= acc_err_d;
      rec_valid_q <= rec_valid_d;
      rec_index_q <= rec_index_d;
      rec_err_q   <= rec_err_d;
      pair_cnt_q  <= pair_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign s_axis_tready = tready;
  assign rec_valid     = rec_valid_q;
  assign rec_index     = rec_index_q;
  assign rec_err       = rec_err_q;
  assign frame_done    = (state_q == ST_DONE);
  assign busy          = (state_q == ST_PAYLOAD);
  assign pair_cnt      = pair_cnt_q;
  assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_axis_pair_stream_checker.sv
module tb_axis_pair_stream_checker;

  localparam int DW = 512;
  localparam int FP = 12;

  logic          aclk = 1'b0;
  logic          areset;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic          rec_valid;
  logic          rec_ready;
  logic [7:0]    rec_index;
  logic [3:0]    rec_err;
  logic          frame_done;
  logic [8:0]    pair_cnt;
  logic [15:0]   err_cnt;
  logic          busy;

  axis_pair_stream_checker #(
    .DATA_W(DW),
    .MARKER(8'h9E),
    .FRAME_PAIRS(FP),
    .CNT_W(16)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast),
    .rec_valid(rec_valid),
    .rec_ready(rec_ready),
    .rec_index(rec_index),
    .rec_err(rec_err),
    .frame_done(frame_done),
    .pair_cnt(pair_cnt),
    .err_cnt(err_cnt),
    .busy(busy)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [7:0] idx;
    logic [3:0] err;
  } rec_t;

  rec_t exp_q[$];

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_exp    = 0;
  int m_pcnt   = 0;
  int m_errs   = 0;
  int m_frames = 0;

  int  seen_frames = 0;
  int  cyc = 0;
  int  fd_last = 0;
  int  fd_gap = 0;
  bit  gaps = 0;
  bit  rdy_rand = 0;
  bit  armed = 0;
  logic [7:0] held_idx;
  logic [3:0] held_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: scoreboard pop on record handshake, plus hold-stability check
  always @(negedge aclk) begin
    cyc++;
    if (frame_done) begin
      seen_frames++;
      fd_gap  = cyc - fd_last;
      fd_last = cyc;
    end
    if (armed) begin
      chk("rec_hold_valid", {31'd0, rec_valid}, 32'd1);
      chk("rec_hold_index", {24'd0, rec_index}, {24'd0, held_idx});
      chk("rec_hold_err", {28'd0, rec_err}, {28'd0, held_err});
      armed = 0;
    end
    if (!areset && rec_valid && !rec_ready) begin
      armed    = 1;
      held_idx = rec_index;
      held_err = rec_err;
    end
    if (!areset && rec_valid && rec_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_record", {24'd0, rec_index}, 32'hFFFF_FFFF);
      end else begin
        rec_t e;
        e = exp_q.pop_front();
        chk("rec_index", {24'd0, rec_index}, {24'd0, e.idx});
        chk("rec_err", {28'd0, rec_err}, {28'd0, e.err});
      end
    end
  end

  // random record-ready backpressure
  always @(posedge aclk) begin
    #1;
    if (rdy_rand) rec_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic junk_inputs();
    for (int i = 0; i < DW / 32; i++) s_axis_tdata[i*32 +: 32] = $urandom;
    s_axis_tlast = $urandom_range(0, 1) == 1;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic l);
    int  n;
    logic acc;
    n = 0;
    if (gaps && $urandom_range(0, 3) == 0) begin
      s_axis_tvalid = 1'b0;
      junk_inputs();
      repeat ($urandom_range(1, 2)) @(posedge aclk);
      #1;
    end
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    forever begin
      @(negedge aclk);
      acc = s_axis_tready;
      @(posedge aclk);
      #1;
      if (acc) break;
      n++;
      if (n > 500) begin
        total++;
        bad++;
        $display("FAIL beat_timeout: got no tready expected accept");
        break;
      end
    end
    s_axis_tvalid = 1'b0;
    junk_inputs();
  endtask

  // model + drive one pair; tpos/ppos = 0 means no nonzero pad byte
  task automatic send_pair(input int tag, input int marker, input int tpos, input int tval,
                           input int ppos, input int pval, input bit tl, input bit pl);
    logic [DW-1:0] td;
    logic [DW-1:0] pd;
    logic [3:0]    e;
    bit            fin;
    rec_t          r;
    fin  = (m_pcnt + 1 == FP);
    e[0] = (tag != m_exp);
    e[1] = (marker != 'h9E);
    e[2] = (tpos != 0) || (ppos != 0);
    e[3] = tl || (pl != fin);
    r.idx = 8'(tag);
    r.err = e;
    exp_q.push_back(r);
    if (e != 4'd0) m_errs++;
    m_exp = (tag + 1) % 256;
    m_pcnt++;
    if (fin || pl) begin
      m_frames++;
      m_exp  = 0;
      m_pcnt = 0;
    end
    td = '0;
    td[7:0] = 8'(tag);
    if (tpos != 0) td[tpos*8 +: 8] = 8'(tval);
    pd = '0;
    pd[7:0] = 8'(marker);
    if (ppos != 0) pd[ppos*8 +: 8] = 8'(pval);
    send_beat(td, tl);
    send_beat(pd, pl);
  endtask

  task automatic clean_frame();
    for (int i = 0; i < FP; i++) send_pair(i, 'h9E, 0, 0, 0, 0, 1'b0, i == FP - 1);
  endtask

  task automatic check_state(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge aclk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_drain: got %0d pending expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge aclk);
    chk({name, "_err_cnt"}, {16'd0, err_cnt}, 32'(m_errs));
    chk({name, "_frames"}, 32'(seen_frames), 32'(m_frames));
    chk({name, "_pair_cnt"}, {23'd0, pair_cnt}, 32'(m_pcnt));
    @(posedge aclk);
    #1;
  endtask

  initial begin
    int fin;
    int tag;
    int mk;
    int tp;
    int pp;
    areset        = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    rec_ready     = 1'b0;

    // reset
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    chk("reset_tready", {31'd0, s_axis_tready}, 32'd0);
    @(posedge aclk);
    #1;
    areset    = 1'b0;
    rec_ready = 1'b1;
    @(negedge aclk);
    chk("reset_rec_valid", {31'd0, rec_valid}, 32'd0);
    chk("reset_rec_index", {24'd0, rec_index}, 32'd0);
    chk("reset_rec_err", {28'd0, rec_err}, 32'd0);
    chk("reset_frame_done", {31'd0, frame_done}, 32'd0);
    chk("reset_pair_cnt", {23'd0, pair_cnt}, 32'd0);
    chk("reset_err_cnt", {16'd0, err_cnt}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    @(posedge aclk);
    #1;

    // two clean back-to-back frames
    clean_frame();
    clean_frame();
    check_state("clean");
    chk("frame_period", 32'(fd_gap), 32'(2 * FP + 1));

    // index skip 0,1,5,6,...
    for (int i = 0; i < FP; i++) begin
      tag = (i < 2) ? i : i + 3;
      send_pair(tag, 'h9E, 0, 0, 0, 0, 1'b0, i == FP - 1);
    end
    check_state("skip");

    // bad marker on pair 3, nonzero tag byte 7 on pair 4
    for (int i = 0; i < FP; i++) begin
      send_pair(i, (i == 3) ? 0 : 'h9E, (i == 4) ? 7 : 0, 'hFF, 0, 0, 1'b0, i == FP - 1);
    end
    check_state("marker_pad");

    // early TLAST on pair 5, then a frame with missing TLAST, then clean
    for (int i = 0; i < 6; i++) send_pair(i, 'h9E, 0, 0, 0, 0, 1'b0, i == 5);
    for (int i = 0; i < FP; i++) send_pair(i, 'h9E, 0, 0, 0, 0, 1'b0, 1'b0);
    clean_frame();
    check_state("tlast");

    // record backpressure
    rec_ready = 1'b0;
    send_pair(0, 'h9E, 0, 0, 0, 0, 1'b0, 1'b0);
    fork
      send_pair(1, 'h9E, 0, 0, 0, 0, 1'b0, 1'b0);
      begin
        int n;
        n = 0;
        do begin
          @(negedge aclk);
          n++;
        end while (!(busy && s_axis_tvalid) && n < 50);
        for (int k = 0; k < 4; k++) begin
          chk("bp_tready_low", {31'd0, s_axis_tready}, 32'd0);
          chk("bp_rec0_index", {24'd0, rec_index}, 32'd0);
          @(negedge aclk);
        end
        @(posedge aclk);
        #1;
        rec_ready = 1'b1;
        @(negedge aclk);
        chk("bp_tready_high", {31'd0, s_axis_tready}, 32'd1);
      end
    join
    for (int i = 2; i < FP; i++) send_pair(i, 'h9E, 0, 0, 0, 0, 1'b0, i == FP - 1);
    check_state("backpressure");

    // reset mid-frame with a record pending
    for (int i = 0; i < 6; i++) send_pair(i, 'h9E, 0, 0, 0, 0, 1'b0, 1'b0);
    rec_ready = 1'b0;
    areset    = 1'b1;
    @(negedge aclk);
    chk("midreset_tready", {31'd0, s_axis_tready}, 32'd0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    chk("midreset_rec_valid", {31'd0, rec_valid}, 32'd0);
    chk("midreset_rec_index", {24'd0, rec_index}, 32'd0);
    chk("midreset_rec_err", {28'd0, rec_err}, 32'd0);
    chk("midreset_pair_cnt", {23'd0, pair_cnt}, 32'd0);
    chk("midreset_err_cnt", {16'd0, err_cnt}, 32'd0);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_frame_done", {31'd0, frame_done}, 32'd0);
    exp_q.delete();
    m_exp       = 0;
    m_pcnt      = 0;
    m_errs      = 0;
    m_frames    = 0;
    seen_frames = 0;
    @(posedge aclk);
    #1;
    rec_ready = 1'b1;
    clean_frame();
    check_state("after_reset");

    // randomized traffic with gaps, backpressure and sparse errors
    gaps     = 1;
    rdy_rand = 1;
    for (int n = 0; n < 300; n++) begin
      fin = (m_pcnt + 1 == FP) ? 1 : 0;
      tag = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 255)) : m_exp;
      mk  = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 255)) : 'h9E;
      tp  = ($urandom_range(0, 24) == 0) ? int'($urandom_range(1, DW / 8 - 1)) : 0;
      pp  = ($urandom_range(0, 24) == 0) ? int'($urandom_range(1, DW / 8 - 1)) : 0;
      send_pair(tag, mk, tp, $urandom_range(1, 255), pp, $urandom_range(1, 255),
                $urandom_range(0, 29) == 0, (fin != 0) ^ ($urandom_range(0, 24) == 0));
    end
    rdy_rand = 0;
    gaps     = 0;
    @(posedge aclk);
    #1;
    rec_ready = 1'b1;
    check_state("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
